// File: rtl/ga_pkg.sv
// Shared GA pipeline constants, index widths and the selection-stage state type.
// Consumed by the selection, mutation and fitness stages.
package ga_pkg;

    localparam int N_POP  = 50;
    localparam int N_SEL  = 10;
    localparam int PATH_W = 150;
    localparam int COST_W = 16;

    localparam int IDX_W  = $clog2(N_POP);
    localparam int SLOT_W = (N_SEL > 1) ? $clog2(N_SEL) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        WRITE,
        DONE
    } sel_state_e;

endpackage

// File: rtl/ga_min_tracker.sv
// Running-minimum tracker: keeps the lowest cost seen since the last clear.
// Strict less-than keeps the earliest index on ties; best_valid admits an all-ones first candidate.
module ga_min_tracker
    import ga_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              cand_valid,
    input  logic [COST_W-1:0] cand_cost,
    input  logic [IDX_W-1:0]  cand_idx,
    output logic [COST_W-1:0] best_cost,
    output logic [IDX_W-1:0]  best_idx,
    output logic              best_valid
);

    logic [COST_W-1:0] r_best_cost;
    logic [IDX_W-1:0]  r_best_idx;
    logic              r_best_valid;
    logic              w_accept;

    assign w_accept = cand_valid && (!r_best_valid || (cand_cost < r_best_cost));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_best_cost  <= '0;
            r_best_idx   <= '0;
            r_best_valid <= 1'b0;
        end else if (clear) begin
            r_best_valid <= 1'b0;
        end else if (w_accept) begin
            r_best_cost  <= cand_cost;
            r_best_idx   <= cand_idx;
            r_best_valid <= 1'b1;
        end
    end

    assign best_cost  = r_best_cost;
    assign best_idx   = r_best_idx;
    assign best_valid = r_best_valid;

endmodule

// File: rtl/ga_selection.sv
// Truncation selection: repeated minimum scans pick the N_SEL cheapest paths,
// one slot per pass of N_POP cycles plus a write cycle, lowest index winning ties.
module ga_selection
    import ga_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [N_POP*PATH_W-1:0]   population,
    input  logic [N_POP*COST_W-1:0]   path_cost,
    output logic [N_SEL*PATH_W-1:0]   sel_population,
    output logic [N_SEL*COST_W-1:0]   sel_cost,
    output logic                      busy,
    output logic                      done
);

    sel_state_e        r_state;
    sel_state_e        w_state_next;
    logic [COST_W-1:0] r_cost [N_POP];
    logic [N_POP-1:0]  r_taken;
    logic [IDX_W-1:0]  r_idx;
    logic [SLOT_W-1:0] r_slot;

    logic [PATH_W-1:0] w_pop [N_POP];
    logic              w_clear;
    logic              w_cand_valid;
    logic              w_last_idx;
    logic              w_last_slot;
    logic              w_write;
    logic [COST_W-1:0] w_best_cost;
    logic [IDX_W-1:0]  w_best_idx;
    logic              w_best_valid;

    genvar gi;
    generate
        for (gi = 0; gi < N_POP; gi++) begin : g_pop
            assign w_pop[gi] = population[gi*PATH_W +: PATH_W];
        end
    endgenerate

    assign w_last_idx  = (r_idx == IDX_W'(N_POP - 1));
    assign w_last_slot = (r_slot == SLOT_W'(N_SEL - 1));
    assign w_write     = (r_state == WRITE) && w_best_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_cand_valid = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_clear      = 1'b1;
                    w_state_next = SCAN;
                end
            end
            SCAN: begin
                busy         = 1'b1;
                w_cand_valid = !r_taken[r_idx];
                if (w_last_idx) begin
                    w_state_next = WRITE;
                end
            end
            WRITE: begin
                busy         = 1'b1;
                w_clear      = 1'b1;
                w_state_next = w_last_slot ? DONE : SCAN;
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_taken <= '0;
            r_idx   <= '0;
            r_slot  <= '0;
            for (int k = 0; k < N_POP; k++) begin
                r_cost[k] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_taken <= '0;
                        r_idx   <= '0;
                        r_slot  <= '0;
                        for (int k = 0; k < N_POP; k++) begin
                            r_cost[k] <= path_cost[k*COST_W +: COST_W];
                        end
                    end
                end
                SCAN: begin
                    r_idx <= w_last_idx ? '0 : r_idx + 1'b1;
                end
                WRITE: begin
                    if (w_best_valid) begin
                        r_taken[w_best_idx] <= 1'b1;
                    end
                    r_idx <= '0;
                    if (!w_last_slot) begin
                        r_slot <= r_slot + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    ga_min_tracker u_min_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (w_clear),
        .cand_valid (w_cand_valid),
        .cand_cost  (r_cost[r_idx]),
        .cand_idx   (r_idx),
        .best_cost  (w_best_cost),
        .best_idx   (w_best_idx),
        .best_valid (w_best_valid)
    );

    // Each output slot owns its register; untouched slots keep the previous run's result.
    generate
        for (gi = 0; gi < N_SEL; gi++) begin : g_slot
            logic [PATH_W-1:0] r_path;
            logic [COST_W-1:0] r_path_cost;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_path      <= '0;
                    r_path_cost <= '0;
                end else if (w_write && (r_slot == SLOT_W'(gi))) begin
                    r_path      <= w_pop[w_best_idx];
                    r_path_cost <= w_best_cost;
                end
            end

            assign sel_population[gi*PATH_W +: PATH_W] = r_path;
            assign sel_cost[gi*COST_W +: COST_W]       = r_path_cost;
        end
    endgenerate

endmodule

// File: tb/tb_ga_selection.sv
// Self-checking bench for ga_selection: directed and random cost sets checked
// against a stable-sort reference model, plus restart-ignore and mid-run reset.
module tb_ga_selection;
    import ga_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    start;
    logic [N_POP*PATH_W-1:0] population;
    logic [N_POP*COST_W-1:0] path_cost;
    logic [N_SEL*PATH_W-1:0] sel_population;
    logic [N_SEL*COST_W-1:0] sel_cost;
    logic                    busy;
    logic                    done;

    int n_vec = 0;
    int n_err = 0;

    logic [PATH_W-1:0] paths [N_POP];
    logic [COST_W-1:0] costs [N_POP];
    int                exp_idx [N_SEL];
    logic [PATH_W-1:0] prev_path [N_SEL];
    logic [COST_W-1:0] prev_cost [N_SEL];

    localparam int LATENCY = N_SEL * (N_POP + 1) + 1;

    always #5 clk = ~clk;

    ga_selection dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .population     (population),
        .path_cost      (path_cost),
        .sel_population (sel_population),
        .sel_cost       (sel_cost),
        .busy           (busy),
        .done           (done)
    );

    task automatic check_eq(input string tag, input logic [PATH_W-1:0] got,
                            input logic [PATH_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_paths();
        logic [159:0] tmp;
        for (int k = 0; k < N_POP; k++) begin
            tmp = {$urandom, $urandom, $urandom, $urandom, $urandom};
            paths[k] = tmp[PATH_W-1:0];
        end
    endtask

    task automatic load_inputs();
        for (int k = 0; k < N_POP; k++) begin
            population[k*PATH_W +: PATH_W] = paths[k];
            path_cost[k*COST_W +: COST_W]  = costs[k];
        end
    endtask

    // Stable sort by cost: key = cost*N_POP + index, so equal costs order by index.
    task automatic build_model();
        longint q[$];
        q = {};
        for (int k = 0; k < N_POP; k++) begin
            q.push_back(longint'(costs[k]) * N_POP + k);
        end
        q.sort();
        for (int j = 0; j < N_SEL; j++) begin
            exp_idx[j] = int'(q[j] % N_POP);
        end
    endtask

    task automatic check_results(input string name);
        for (int j = 0; j < N_SEL; j++) begin
            check_eq($sformatf("%s_path%0d", name, j),
                     sel_population[j*PATH_W +: PATH_W], paths[exp_idx[j]]);
            check_eq($sformatf("%s_cost%0d", name, j),
                     PATH_W'(sel_cost[j*COST_W +: COST_W]), PATH_W'(costs[exp_idx[j]]));
            prev_path[j] = paths[exp_idx[j]];
            prev_cost[j] = costs[exp_idx[j]];
        end
    endtask

    task automatic check_zero_outputs(input string name);
        check_eq({name, "_busy"}, PATH_W'(busy), '0);
        check_eq({name, "_done"}, PATH_W'(done), '0);
        for (int j = 0; j < N_SEL; j++) begin
            check_eq($sformatf("%s_path%0d", name, j), sel_population[j*PATH_W +: PATH_W], '0);
            check_eq($sformatf("%s_cost%0d", name, j), PATH_W'(sel_cost[j*COST_W +: COST_W]), '0);
            prev_path[j] = '0;
            prev_cost[j] = '0;
        end
    endtask

    // One selection run; optional re-start (with new costs) at cycle restart_at.
    task automatic run_op(input string name, input int restart_at);
        int cyc;
        int done_cyc;
        load_inputs();
        build_model();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        done_cyc = -1;
        check_eq({name, "_busy_c1"}, PATH_W'(busy), PATH_W'(1));
        while (cyc < 2000) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (cyc == N_POP + 2) begin
                // slot 0 just written, slot 1 must still hold the previous run
                check_eq({name, "_early_slot0"}, sel_population[0 +: PATH_W], paths[exp_idx[0]]);
                check_eq({name, "_early_slot1"}, sel_population[PATH_W +: PATH_W], prev_path[1]);
            end
            if (restart_at > 0 && cyc == restart_at) begin
                start = 1'b1;
                for (int k = 0; k < N_POP; k++) begin
                    path_cost[k*COST_W +: COST_W] = COST_W'($urandom);
                end
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        $display("run %s: done at cycle %0d", name, done_cyc);
        check_eq({name, "_latency"}, PATH_W'(done_cyc), PATH_W'(LATENCY));
        check_results(name);
        tick();
        check_eq({name, "_done_pulse"}, PATH_W'(done), '0);
        check_eq({name, "_idle_busy"}, PATH_W'(busy), '0);
        tick();
        tick();
        check_eq({name, "_still_idle"}, PATH_W'(busy), '0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        population = '0;
        path_cost  = '0;
        tick();
        tick();
        tick();
        check_zero_outputs("reset");
        rst_n = 1'b1;
        tick();

        randomize_paths();
        for (int k = 0; k < N_POP; k++) costs[k] = COST_W'(k);
        run_op("ascend", 0);

        randomize_paths();
        for (int k = 0; k < N_POP; k++) costs[k] = COST_W'(N_POP - 1 - k);
        run_op("descend", 0);

        for (int k = 0; k < N_POP; k++) costs[k] = 16'hFFFF;
        run_op("all_ones", 0);

        for (int k = 0; k < N_POP; k++) costs[k] = 16'h0005;
        run_op("all_five", 0);

        randomize_paths();
        for (int k = 0; k < N_POP; k++) costs[k] = 16'd100;
        costs[7]  = 16'd3;
        costs[30] = 16'd3;
        costs[2]  = 16'd1;
        run_op("mixed", 0);

        for (int r = 0; r < 4; r++) begin
            randomize_paths();
            for (int k = 0; k < N_POP; k++) begin
                costs[k] = (r < 2) ? COST_W'($urandom_range(0, 7)) : COST_W'($urandom);
            end
            run_op($sformatf("rand%0d", r), 0);
        end

        randomize_paths();
        for (int k = 0; k < N_POP; k++) costs[k] = COST_W'($urandom_range(0, 300));
        run_op("restart", 100);

        // Reset in the middle of a run abandons it and clears the outputs.
        randomize_paths();
        for (int k = 0; k < N_POP; k++) costs[k] = COST_W'($urandom);
        load_inputs();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 200; c++) tick();
        rst_n = 1'b0;
        tick();
        check_zero_outputs("midreset");
        rst_n = 1'b1;
        tick();
        check_eq("midreset_idle_busy", PATH_W'(busy), '0);
        run_op("after_reset", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
